// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction-fetch front end feeding the IF/ID register.
//
// Owns the fetch PC and issues word fetches to a variable-latency instruction memory over a
// req/ack handshake. Each returned word is stored with its PC+4 in a DEPTH-entry FIFO. Decode
// drains the FIFO head under id_stall. A redirect flushes the FIFO and discards any in-flight
// fetch. The flush takes effect immediately if the fetch is acked in the same cycle. Otherwise
// the FSM waits in StDrain for the ack.
//
// Ports:
//   clk, reset               clock (rising edge), synchronous active-high reset
//   imem_req/imem_addr       fetch request and word address, held until imem_ack
//   imem_ack/imem_rdata      fetch response and instruction word
//   redirect/redirect_pc     taken branch/jump and its target (bits [1:0] ignored)
//   id_stall                 decode is not accepting; the head entry is held
//   id_valid/id_instr/id_pc4 FIFO head; instr and pc4 read as zero when id_valid is low
//
// Optional build macro IFQ_BYPASS_EN: when the FIFO is empty, a word acked in StReq is
// presented on id_* in the same cycle. It is consumed directly unless decode stalls, in
// which case it is pushed as usual. Without the macro, id_* come only from FIFO registers.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StDrain} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     req_addr_q, req_addr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     instr_q [DEPTH];
  logic [31:0]     instr_d [DEPTH];
  logic [31:0]     pc4_q   [DEPTH];
  logic [31:0]     pc4_d   [DEPTH];

  logic            fifo_valid, fetch_ok, bypass, push, pop;
  logic [31:0]     req_addr_inc, redirect_aligned;
  logic [CntW-1:0] count_pp;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign redirect_aligned    = {redirect_pc[31:2], 2'b00};
  assign req_addr_inc        = req_addr_q + 32'd4;  // wraps modulo 2^32
  assign fifo_valid          = (count_q != '0);
  // A useful fetch completes: acked in StReq and not killed by a redirect this cycle.
  assign fetch_ok            = (state_q == StReq) && imem_ack && !redirect;

`ifdef IFQ_BYPASS_EN
  assign bypass = fetch_ok && !fifo_valid;
`else
  assign bypass = 1'b0;
`endif

  assign pop      = fifo_valid && !id_stall && !redirect;
  // A bypassed word taken by decode never enters the FIFO.
  assign push     = fetch_ok && !(bypass && !id_stall);
  assign count_pp = count_q + CntW'(push) - CntW'(pop);

  always_comb begin
    imem_req  = (state_q != StIdle);
    imem_addr = imem_req ? req_addr_q : 32'h0;
    id_valid  = fifo_valid || bypass;
    id_instr  = 32'h0;
    id_pc4    = 32'h0;
    if (fifo_valid) begin
      id_instr = instr_q[rd_ptr_q];
      id_pc4   = pc4_q[rd_ptr_q];
    end else if (bypass) begin
      id_instr = imem_rdata;
      id_pc4   = req_addr_inc;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_pp;
    instr_d    = instr_q;
    pc4_d      = pc4_q;

    if (push) begin
      instr_d[wr_ptr_q] = imem_rdata;
      pc4_d[wr_ptr_q]   = req_addr_inc;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (fetch_ok) begin
      pc_d = req_addr_inc;
    end

    unique case (state_q)
      StIdle: begin
        if (count_q < DepthCnt) begin
          state_d    = StReq;
          req_addr_d = pc_q;
        end
      end
      StReq: begin
        if (imem_ack) begin
          // Keep streaming while there is room for the next word, else park.
          if (count_pp < DepthCnt) begin
            req_addr_d = req_addr_inc;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StDrain: begin
        // The stale word is dropped; resume from the redirect target.
        if (imem_ack) begin
          if (count_pp < DepthCnt) begin
            state_d    = StReq;
            req_addr_d = pc_q;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      pc_d     = redirect_aligned;
      if ((state_q == StIdle) || imem_ack) begin
        state_d    = StReq;
        req_addr_d = redirect_aligned;
      end else begin
        // The fetch is still outstanding. Keep its address stable until the ack.
        state_d = StDrain;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      req_addr_q <= 32'h0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage is qualified by count, so it needs no reset.
  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    pc4_q   <= pc4_d;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end for the pipelined MIPS core. Sits directly upstream of the IF/ID pipeline register and replaces the direct PC→rom32 path.
- Owns the fetch PC and issues word fetches to a variable-latency instruction memory over a req/ack handshake.
- Buffers returned instructions, each paired with its PC+4, in a small FIFO. Decode drains the FIFO under a stall signal.
- Branch/jump redirects flush the FIFO and discard any in-flight fetch.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset; word aligned.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  32  fetch address, word aligned; stable while imem_req=1.
- imem_ack  in  1  response valid; meaningful only while imem_req=1.
- imem_rdata  in  32  instruction word; valid with imem_ack.
- redirect  in  1  taken branch/jump; overrides all other activity this cycle.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored and forced to 0.
- id_stall  in  1  decode not accepting; the head entry is held.
- id_valid  out  1  head entry valid (FIFO not empty).
- id_instr  out  32  head instruction; 32'h0 (NOP) when id_valid=0.
- id_pc4  out  32  head instruction address + 4; 32'h0 when id_valid=0.

Behaviour:
- Reset: pc=RESET_PC, FIFO empty, FSM=IDLE, imem_req=0, imem_addr=0, id_valid=0, id_instr=0, id_pc4=0. Reset mid-fetch abandons the request; the memory must tolerate a dropped req.
- State machine:
  - IDLE: if credit is available (count<DEPTH, counting no outstanding fetch), go to REQ next cycle with req_addr=pc.
  - REQ: imem_req=1, imem_addr=req_addr.
    - On ack without redirect: push {imem_rdata, req_addr+4} and set pc=req_addr+4.
    - After that push, if count_after_pop_push<DEPTH, stay in REQ with req_addr=pc+4 (back-to-back fetch). Otherwise go to IDLE.
  - DRAIN: imem_req=1, imem_addr held at the stale address. On ack, discard the data. Then go to REQ with req_addr=pc if credit is available (always true after a flush), else IDLE.
- Redirect, in every state: FIFO count=0, pc=redirect_pc.
  - IDLE: go to REQ with req_addr=redirect_pc.
  - REQ/DRAIN with no ack this cycle: go to DRAIN.
  - REQ/DRAIN with ack this cycle: discard the data and go to REQ with req_addr=redirect_pc.
- Pop: when id_valid=1, id_stall=0 and redirect=0, the head advances at the clock edge.
- Simultaneous push and pop: the count is unchanged. Push into a full FIFO is impossible by the credit rule.
- Outputs id_* are driven from the FIFO head register/array. An instruction acked in cycle N is visible no earlier than cycle N+1.
- Throughput: one instruction per cycle when imem_ack=1 every cycle and id_stall=0.
- Addresses: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0). No exception is raised.
- FIFO pointers: log2(DEPTH) bits, plus a separate count of log2(DEPTH)+1 bits.

Optional Feature:
- Macro IFQ_BYPASS_EN.
- Defined: when the FIFO is empty, the FSM is in REQ, imem_ack=1 and redirect=0, then id_valid=1, id_instr=imem_rdata and id_pc4=req_addr+4 combinationally in the same cycle.
  - If id_stall=0, the word is consumed and not pushed.
  - If id_stall=1, it is pushed as normal.
- Undefined: the one-cycle minimum latency above applies. Outputs are never combinational from imem_*.

Test Plan:
1. Reset, zero-wait memory (ack whenever req), id_stall=0 → addresses 0,4,8,… issued on consecutive cycles; id_valid first high in cycle 2 after reset release; id_pc4 sequence 4,8,12.
2. id_stall=1 held for 10 cycles, ack always → exactly DEPTH=4 entries fetched (addresses 0,4,8,12); imem_req low afterwards; release the stall → 4 pops in order, then fetching resumes at 16.
3. Memory with 3-cycle ack latency, redirect to 32'h0000_0100 on the second cycle of a pending fetch of 0x8 → imem_addr stays 0x8 until ack; that data never appears on id_*; next request is 0x100.
4. Redirect with redirect_pc=32'h0000_0203 while the FIFO holds 3 entries → id_valid=0 next cycle; next fetch address is 0x200; stale entries never appear.
5. RESET_PC=32'hFFFF_FFF8, zero-wait memory → fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; id_pc4 for the second fetch is 32'h0.
6. Assert reset for 1 cycle while REQ is pending and the FIFO holds 2 entries → imem_req=0 and id_valid=0 next cycle; fetch restarts at RESET_PC.
